// File: rtl/vj_scan_scheduler_if.sv
// Handshake and status bundle between the scan scheduler, the integral-window
// fetch unit, the classifier pipeline and the top-level controller.
interface vj_scan_scheduler_if #(
  parameter int unsigned NUM_LEVELS = 8
);
  // Controller side
  logic                           start;
  logic                           abort;
  logic [NUM_LEVELS-1:0][9:0]     level_w;
  logic [NUM_LEVELS-1:0][9:0]     level_h;
  logic                           busy;
  logic                           done;
  logic [31:0]                    win_count;
  logic [15:0]                    face_count;

  // Fetch unit side
  logic                           fetch_req;
  logic [9:0]                     fetch_x;
  logic [9:0]                     fetch_y;
  logic [3:0]                     fetch_level;
  logic                           fetch_ack;

  // Pipeline side
  logic                           vj_pipeline_on;
  logic                           next_scan_win;
  logic [1:0][31:0]               scan_win_index;
  logic [3:0]                     img_index;
  logic                           top_left_ready;

  // Scheduler view
  modport master (
    input  start, abort, level_w, level_h, fetch_ack, next_scan_win, top_left_ready,
    output busy, done, win_count, face_count, fetch_req, fetch_x, fetch_y, fetch_level,
           vj_pipeline_on, scan_win_index, img_index
  );

  // Environment view (controller, fetch unit, pipeline)
  modport slave (
    output start, abort, level_w, level_h, fetch_ack, next_scan_win, top_left_ready,
    input  busy, done, win_count, face_count, fetch_req, fetch_x, fetch_y, fetch_level,
           vj_pipeline_on, scan_win_index, img_index
  );
endinterface

// File: rtl/vj_scan_scheduler.sv
// Viola-Jones scan scheduler: walks every window of every valid pyramid level,
// fetches it, hands it to the pipeline, then drains and reports detections.
module vj_scan_scheduler #(
  parameter int unsigned NUM_LEVELS   = 8,
  parameter int unsigned WIN          = 24,
  parameter int unsigned STEP         = 1,
  parameter int unsigned DRAIN_CYCLES = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  vj_scan_scheduler_if.master bus
);

  localparam int unsigned DIM_W = 10;
  localparam int unsigned CRD_W = 11;
  localparam int unsigned SUM_W = 12;
  localparam int unsigned LVL_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned FC_W  = 16;
  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [SUM_W-1:0] WIN_S     = SUM_W'(WIN);
  localparam logic [CRD_W-1:0] STEP_C    = CRD_W'(STEP);
  localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [FC_W-1:0]  FC_MAX    = {FC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_READY = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                          state_q, state_d;
  logic [LVL_W-1:0]                lvl_q, lvl_d;
  logic [CRD_W-1:0]                x_q, x_d;
  logic [CRD_W-1:0]                y_q, y_d;
  logic [NUM_LEVELS-1:0][DIM_W-1:0] w_q, w_d;
  logic [NUM_LEVELS-1:0][DIM_W-1:0] h_q, h_d;
  logic [DRN_W-1:0]                drain_q, drain_d;
  logic [CNT_W-1:0]                win_cnt_q, win_cnt_d;
  logic [FC_W-1:0]                 face_cnt_q, face_cnt_d;
  logic                            fetch_req_q, fetch_req_d;
  logic                            vj_on_q, vj_on_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic [CRD_W-1:0]                scan_x_q, scan_x_d;
  logic [CRD_W-1:0]                scan_y_q, scan_y_d;
  logic [LVL_W-1:0]                img_q, img_d;

  logic                            start_found;
  logic [LVL_W-1:0]                start_lvl;
  logic                            next_found;
  logic [LVL_W-1:0]                next_lvl;
  logic [DIM_W-1:0]                cur_w;
  logic [DIM_W-1:0]                cur_h;
  logic [CRD_W-1:0]                x_nxt;
  logic [CRD_W-1:0]                y_nxt;
  logic                            x_fits;
  logic                            y_fits;

  assign x_nxt  = x_q + STEP_C;
  assign y_nxt  = y_q + STEP_C;
  assign x_fits = (({1'b0, x_nxt} + WIN_S) <= {2'b00, cur_w});
  assign y_fits = (({1'b0, y_nxt} + WIN_S) <= {2'b00, cur_h});

  // First valid level of the incoming dimensions, next valid level after the
  // current one, and the current level's latched dimensions.
  always_comb begin
    start_found = 1'b0;
    start_lvl   = '0;
    next_found  = 1'b0;
    next_lvl    = '0;
    cur_w       = '0;
    cur_h       = '0;
    for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
      if (({2'b00, bus.level_w[i]} >= WIN_S) && ({2'b00, bus.level_h[i]} >= WIN_S)) begin
        start_found = 1'b1;
        start_lvl   = LVL_W'(i);
      end
      if ((LVL_W'(i) > lvl_q) && ({2'b00, w_q[i]} >= WIN_S) && ({2'b00, h_q[i]} >= WIN_S)) begin
        next_found = 1'b1;
        next_lvl   = LVL_W'(i);
      end
      if (LVL_W'(i) == lvl_q) begin
        cur_w = w_q[i];
        cur_h = h_q[i];
      end
    end
  end

  // Next-state, scan position, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    lvl_d      = lvl_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    drain_d    = drain_q;
    win_cnt_d  = win_cnt_q;
    face_cnt_d = face_cnt_q;

    if (bus.top_left_ready && (state_q != S_IDLE) && (face_cnt_q != FC_MAX)) begin
      face_cnt_d = face_cnt_q + FC_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_d        = bus.level_w;
          h_d        = bus.level_h;
          win_cnt_d  = '0;
          face_cnt_d = '0;
          lvl_d      = start_lvl;
          x_d        = '0;
          y_d        = '0;
          state_d    = start_found ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (bus.fetch_ack) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (bus.next_scan_win) begin
          win_cnt_d = win_cnt_q + CNT_W'(1);
          state_d   = S_FETCH;
          if (x_fits) begin
            x_d = x_nxt;
          end else if (y_fits) begin
            x_d = '0;
            y_d = y_nxt;
          end else if (next_found) begin
            lvl_d = next_lvl;
            x_d   = '0;
            y_d   = '0;
          end else begin
            state_d = S_DRAIN;
            drain_d = DRN_LOAD;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel overrides everything, including a same-cycle start or detection.
    if (bus.abort) begin
      state_d    = S_IDLE;
      lvl_d      = lvl_q;
      x_d        = x_q;
      y_d        = y_q;
      w_d        = w_q;
      h_d        = h_q;
      drain_d    = drain_q;
      win_cnt_d  = win_cnt_q;
      face_cnt_d = face_cnt_q;
    end

    fetch_req_d = (state_d == S_FETCH);
    vj_on_d     = (state_d == S_READY);
    busy_d      = (state_d == S_FETCH) || (state_d == S_READY) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);

    // Presented window follows the position while READY and holds otherwise.
    scan_x_d = scan_x_q;
    scan_y_d = scan_y_q;
    img_d    = img_q;
    if (state_d == S_READY) begin
      scan_x_d = x_d;
      scan_y_d = y_d;
      img_d    = lvl_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lvl_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      drain_q     <= '0;
      win_cnt_q   <= '0;
      face_cnt_q  <= '0;
      fetch_req_q <= 1'b0;
      vj_on_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      scan_x_q    <= '0;
      scan_y_q    <= '0;
      img_q       <= '0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      drain_q     <= drain_d;
      win_cnt_q   <= win_cnt_d;
      face_cnt_q  <= face_cnt_d;
      fetch_req_q <= fetch_req_d;
      vj_on_q     <= vj_on_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      scan_x_q    <= scan_x_d;
      scan_y_q    <= scan_y_d;
      img_q       <= img_d;
    end
  end

  assign bus.fetch_req         = fetch_req_q;
  assign bus.fetch_x           = x_q[DIM_W-1:0];
  assign bus.fetch_y           = y_q[DIM_W-1:0];
  assign bus.fetch_level       = lvl_q;
  assign bus.vj_pipeline_on    = vj_on_q;
  assign bus.scan_win_index[0] = CNT_W'(scan_x_q);
  assign bus.scan_win_index[1] = CNT_W'(scan_y_q);
  assign bus.img_index         = img_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.win_count         = win_cnt_q;
  assign bus.face_count        = face_cnt_q;

endmodule

// File: tb/tb_vj_scan_scheduler.sv
// Directed bench for vj_scan_scheduler: table of scan configurations with
// expected window order, plus hand sequences for stalls, detections, abort
// and asynchronous reset.
module tb_vj_scan_scheduler;

  localparam int unsigned NL    = 3;
  localparam int unsigned DRAIN = 6;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  vj_scan_scheduler_if #(.NUM_LEVELS(NL)) bus();

  vj_scan_scheduler #(
    .NUM_LEVELS  (NL),
    .WIN         (24),
    .STEP        (1),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [NL-1:0][9:0] lw;
    logic [NL-1:0][9:0] lh;
    int                 nwin;
    int                 first;
  } case_t;

  typedef struct {
    int x;
    int y;
    int img;
  } win_t;

  case_t cases[4];
  win_t  wins[13];
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_case(input int c, input int w0, input int h0, input int w1, input int h1,
                          input int w2, input int h2, input int nwin, input int first);
    cases[c].lw[0] = 10'(w0); cases[c].lh[0] = 10'(h0);
    cases[c].lw[1] = 10'(w1); cases[c].lh[1] = 10'(h1);
    cases[c].lw[2] = 10'(w2); cases[c].lh[2] = 10'(h2);
    cases[c].nwin  = nwin;
    cases[c].first = first;
  endtask

  task automatic set_win(input int i, input int x, input int y, input int img);
    wins[i].x = x; wins[i].y = y; wins[i].img = img;
  endtask

  task automatic apply_levels(input int c);
    bus.level_w = cases[c].lw;
    bus.level_h = cases[c].lh;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_vj();
    int n = 0;
    while (!bus.vj_pipeline_on && n < 20) begin
      tick();
      n++;
    end
    check("vj_wait", 32'(bus.vj_pipeline_on), 1);
  endtask

  // Hold the window one cycle after the rising edge, then consume it.
  task automatic consume();
    tick();
    bus.next_scan_win = 1'b1;
    tick();
    bus.next_scan_win = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run_case(input int c);
    int   n;
    win_t w;
    win_t nw;
    apply_levels(c);
    bus.fetch_ack = 1'b1;
    do_start();
    check("start_win_clear", bus.win_count, 0);
    if (cases[c].nwin == 0) begin
      check("empty_done", 32'(bus.done), 1);
      check("empty_busy", 32'(bus.busy), 0);
      check("empty_req", 32'(bus.fetch_req), 0);
      tick();
      check("empty_req_later", 32'(bus.fetch_req), 0);
      check("empty_done_hold", 32'(bus.done), 1);
    end else begin
      w = wins[cases[c].first];
      check("start_done_clr", 32'(bus.done), 0);
      check("start_fetch_req", 32'(bus.fetch_req), 1);
      check("start_fetch_x", 32'(bus.fetch_x), w.x);
      check("start_fetch_y", 32'(bus.fetch_y), w.y);
      check("start_fetch_lvl", 32'(bus.fetch_level), w.img);
      for (int k = 0; k < cases[c].nwin; k++) begin
        w = wins[cases[c].first + k];
        wait_vj();
        check("win_x", bus.scan_win_index[0], w.x);
        check("win_y", bus.scan_win_index[1], w.y);
        check("win_img", 32'(bus.img_index), w.img);
        consume();
        check("vj_drop", 32'(bus.vj_pipeline_on), 0);
        check("win_count", bus.win_count, k + 1);
        check("busy_run", 32'(bus.busy), 1);
        if (k < cases[c].nwin - 1) begin
          nw = wins[cases[c].first + k + 1];
          check("next_req", 32'(bus.fetch_req), 1);
          check("next_fetch_x", 32'(bus.fetch_x), nw.x);
          check("next_fetch_y", 32'(bus.fetch_y), nw.y);
          check("next_fetch_lvl", 32'(bus.fetch_level), nw.img);
        end else begin
          check("drain_no_req", 32'(bus.fetch_req), 0);
          wait_done(n);
          check("drain_len", n, DRAIN);
          check("done_busy", 32'(bus.busy), 0);
          check("done_hold_idx_y", bus.scan_win_index[1], w.y);
        end
      end
    end
  endtask

  initial begin
    int n;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.level_w        = '0;
    bus.level_h        = '0;
    bus.fetch_ack      = 1'b0;
    bus.next_scan_win  = 1'b0;
    bus.top_left_ready = 1'b0;

    // Configurations: 26x25 single level, skipped middle level, nothing valid,
    // first level invalid with two sizes of valid level after it.
    set_case(0, 26, 25, 10, 10, 10, 10, 6, 0);
    set_case(1, 24, 24, 20, 30, 24, 24, 2, 6);
    set_case(2, 10, 10, 10, 10, 10, 10, 0, 0);
    set_case(3, 10, 10, 25, 24, 24, 26, 5, 8);
    set_win(0, 0, 0, 0); set_win(1, 1, 0, 0); set_win(2, 2, 0, 0);
    set_win(3, 0, 1, 0); set_win(4, 1, 1, 0); set_win(5, 2, 1, 0);
    set_win(6, 0, 0, 0); set_win(7, 0, 0, 2);
    set_win(8, 0, 0, 1); set_win(9, 1, 0, 1); set_win(10, 0, 0, 2);
    set_win(11, 0, 1, 2); set_win(12, 0, 2, 2);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", 32'(bus.fetch_req), 0);
    check("rst_vj", 32'(bus.vj_pipeline_on), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_win", bus.win_count, 0);
    check("rst_face", 32'(bus.face_count), 0);
    reset_n = 1'b1;
    tick();

    for (int c = 0; c < 4; c++) begin
      run_case(c);
    end

    // Stalled fetch on window 2 with stray consume pulses
    apply_levels(0);
    bus.fetch_ack = 1'b0;
    do_start();
    check("dly_req0", 32'(bus.fetch_req), 1);
    bus.fetch_ack = 1'b1;
    tick();
    bus.fetch_ack = 1'b0;
    check("dly_vj0", 32'(bus.vj_pipeline_on), 1);
    consume();
    for (int i = 0; i < 5; i++) begin
      check("dly_req", 32'(bus.fetch_req), 1);
      check("dly_x", 32'(bus.fetch_x), 1);
      check("dly_y", 32'(bus.fetch_y), 0);
      check("dly_vj_low", 32'(bus.vj_pipeline_on), 0);
      bus.next_scan_win = ((i % 2) == 0);
      tick();
    end
    bus.next_scan_win = 1'b0;
    check("dly_win_hold", bus.win_count, 1);
    bus.fetch_ack = 1'b1;
    tick();
    bus.fetch_ack = 1'b0;
    check("dly_vj1", 32'(bus.vj_pipeline_on), 1);
    check("dly_scan_x", bus.scan_win_index[0], 1);
    // start while busy is ignored
    do_start();
    check("busy_start_vj", 32'(bus.vj_pipeline_on), 1);
    check("busy_start_win", bus.win_count, 1);
    check("busy_start_x", bus.scan_win_index[0], 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort1_busy", 32'(bus.busy), 0);
    check("abort1_vj", 32'(bus.vj_pipeline_on), 0);
    check("abort1_win", bus.win_count, 1);

    // Detection counting across READY, DRAIN, IDLE and DONE
    apply_levels(1);
    bus.fetch_ack = 1'b1;
    do_start();
    wait_vj();
    bus.top_left_ready = 1'b1;
    tick();
    bus.top_left_ready = 1'b0;
    consume();
    wait_vj();
    tick();
    bus.next_scan_win  = 1'b1;
    bus.top_left_ready = 1'b1;
    tick();
    bus.next_scan_win  = 1'b0;
    bus.top_left_ready = 1'b1;
    tick();
    bus.top_left_ready = 1'b0;
    wait_done(n);
    check("face_done", 32'(bus.done), 1);
    check("face_count3", 32'(bus.face_count), 3);
    check("face_win2", bus.win_count, 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("face_abort_hold", 32'(bus.face_count), 3);
    bus.top_left_ready = 1'b1;
    tick();
    bus.top_left_ready = 1'b0;
    check("face_idle_ignored", 32'(bus.face_count), 3);
    apply_levels(2);
    do_start();
    check("face_restart_clr", 32'(bus.face_count), 0);
    check("restart_done", 32'(bus.done), 1);
    bus.start          = 1'b1;
    bus.top_left_ready = 1'b1;
    tick();
    bus.start          = 1'b0;
    bus.top_left_ready = 1'b0;
    check("face_start_drop", 32'(bus.face_count), 0);
    bus.top_left_ready = 1'b1;
    tick();
    bus.top_left_ready = 1'b0;
    check("face_done_count", 32'(bus.face_count), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_done_clr", 32'(bus.done), 0);

    // Abort in READY at window 4
    apply_levels(0);
    bus.fetch_ack = 1'b1;
    do_start();
    for (int k = 0; k < 3; k++) begin
      wait_vj();
      consume();
    end
    wait_vj();
    check("w4_x", bus.scan_win_index[0], 0);
    check("w4_y", bus.scan_win_index[1], 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_vj", 32'(bus.vj_pipeline_on), 0);
    check("abort_req", 32'(bus.fetch_req), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_win3", bus.win_count, 3);
    // abort beats a same-cycle start
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_wins_req", 32'(bus.fetch_req), 0);
    check("abort_wins_win", bus.win_count, 3);

    // Asynchronous reset mid-FETCH
    bus.fetch_ack = 1'b0;
    do_start();
    check("run2_req", 32'(bus.fetch_req), 1);
    check("run2_busy", 32'(bus.busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.fetch_req), 0);
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_vj", 32'(bus.vj_pipeline_on), 0);
    check("arst_scan_y", bus.scan_win_index[1], 0);
    check("arst_face", 32'(bus.face_count), 0);
    reset_n = 1'b1;
    tick();
    check("post_rst_req", 32'(bus.fetch_req), 0);
    check("post_rst_done", 32'(bus.done), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached after %0d tests", tests);
    $fatal(1);
  end

endmodule
